led_pattern_driver: RTL
=======================

# led_pattern_driver

Parametrised multi-channel LED driver. It succeeds the fixed free-running blink counter. A shared prescaler and PWM counter drive NUM_CH independent channels. Each channel is runtime-configurable as off, on, blink, fixed-duty PWM or breathe. It sits between the board-level top (clock pin, reset button, LED pins) and any logic that wants to signal status on LEDs.

## Interface
- NUM_CH, 2, number of LED channels (1..16)
- PRESCALE_DIV, 65536, clk_in cycles per pattern tick (≥2)
- PWM_W, 8, PWM counter / duty / config value width
- clk_in  input  1  single system clock
- reset_in  input  1  synchronous, active-high reset
- cfg_we  input  1  config write strobe, one cycle per write
- cfg_ch  input  max(1,$clog2(NUM_CH))  target channel
- cfg_mode  input  3  0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BREATHE; 5–7 behave as OFF
- cfg_val  input  PWM_W  mode argument: BLINK half-period in ticks, PWM duty, BREATHE peak duty
- led_out  output  NUM_CH  registered LED drive, bit i = channel i
- tick_out  output  1  one-cycle pulse per prescaler wrap

## Operation
- Reset behaviour: while reset_in is high at a rising edge, every register clears.
  - All modes become OFF and all values 0.
  - Prescaler, PWM counter and per-channel state go to 0.
  - led_out=0, tick_out=0.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1 and wraps to 0.
  - tick (internal, and registered as tick_out) is high for the cycle in which the count equals PRESCALE_DIV-1.
- PWM counter:
  - PWM_W bits, increments every cycle, wraps from all-ones to 0.
  - Compare is strict: on = pwm_cnt < duty.
  - Duty 0 gives always off; duty all-ones gives 1 off cycle per 2^PWM_W.
- Per-channel state: mode, val, blink counter, blink phase, ramp, direction.
- OFF: led 0. ON: led 1.
- BLINK:
  - Counter increments on tick.
  - When the counter reaches max(val,1), the phase toggles and the counter clears.
  - led = phase, and phase starts at 0 after a write.
  - Period is 2·max(val,1) ticks.
- PWM: led = pwm_cnt < val.
- BREATHE:
  - Ramp steps by 1 per tick, up to val, then down to 0, repeating.
  - The direction flips on the tick that lands the ramp on val or on 0.
  - led = pwm_cnt < ramp.
  - val=0 gives led constantly 0.
- Config write, applied when cfg_we is high at an edge:
  - If cfg_ch < NUM_CH, that channel's mode and val are loaded.
  - Its blink counter, phase and ramp clear, and direction becomes up.
  - cfg_ch ≥ NUM_CH: the write is ignored with no side effects.
  - Other channels are never disturbed.
- Simultaneous tick and write on the same channel: the write wins and that tick is not applied to the channel.
- Changing val by rewriting the same mode still restarts the channel state.

## Timing
- Write sampled at edge N: config registers hold the new values after N, and led_out reflects the new mode after edge N+1.
- led_out is one register stage after the compare/phase logic, so its latency from any internal state change is 1 cycle.
- tick_out is high during the cycle after the prescaler reaches PRESCALE_DIV-1.
  - First pulse after reset: tick_out is observed high after edge PRESCALE_DIV.
  - It then pulses every PRESCALE_DIV cycles exactly.
- Reset mid-operation: outputs are 0 one edge after reset_in is sampled high, regardless of mode or phase.
- No backpressure: a write is accepted every cycle.

## Structure
- Package led_pattern_pkg:
  - mode enum led_mode_t (3 bits, OFF/ON/BLINK/PWM/BREATHE)
  - mode-decoding helper
- Top led_pattern_driver owns the prescaler, PWM counter and config decode.
- Sub-module led_pattern_channel:
  - One instance per channel via generate.
  - Inputs: clk_in, reset_in, tick, pwm_cnt, load, mode, val.
  - Output: registered led.

## Test plan
- Reset then idle, with PRESCALE_DIV=4 and PWM_W=4:
  - led_out=0 throughout.
  - tick_out pulses at cycles 4, 8, 12….
- ch0 ON, ch1 PWM val=4 (PWM_W=4):
  - ch0 is 1 one cycle after the write.
  - ch1 is high exactly 4 of every 16 cycles.
  - ch1 duty 0 gives 0 and duty 15 gives 15/16.
- ch1 BLINK val=3 (PRESCALE_DIV=4):
  - led toggles every 12 cycles, first rising 12 cycles after the write.
  - val=0 toggles every tick.
- ch0 BREATHE val=3:
  - Ramp sequence per tick is 0,1,2,3,2,1,0,1…
  - Measured high count per 16-cycle PWM window matches the ramp.
- Same-cycle cfg_we to ch1 and tick:
  - Blink counter restarts from 0 with no extra step.
  - cfg_ch=NUM_CH write changes nothing.
- reset_in pulsed mid-blink or mid-breathe: all outputs are 0 next edge, and state restarts from OFF.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern driver: channel mode encoding and the
// decode that folds unused mode codes onto OFF.
package led_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4
    } led_mode_t;

    function automatic led_mode_t decode_mode(input logic [2:0] raw);
        led_mode_t m;
        case (raw)
            3'd1:    m = MODE_ON;
            3'd2:    m = MODE_BLINK;
            3'd3:    m = MODE_PWM;
            3'd4:    m = MODE_BREATHE;
            default: m = MODE_OFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/led_pattern_channel.sv
// One LED channel: holds its mode/argument and blink/breathe state, and
// registers the resulting LED drive.
module led_pattern_channel
    import led_pattern_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             tick,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             load,
    input  logic [2:0]       mode,
    input  logic [PWM_W-1:0] val,
    output logic             led
);

    led_mode_t        mode_q, mode_d;
    logic [PWM_W-1:0] val_q, val_d;
    logic [PWM_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic [PWM_W-1:0] ramp_q, ramp_d;
    logic             dir_down_q, dir_down_d;
    logic             led_q, led_d;

    logic [PWM_W-1:0] half_period;
    logic [PWM_W:0]   blink_next;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        mode_d      = mode_q;
        val_d       = val_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        ramp_d      = ramp_q;
        dir_down_d  = dir_down_q;
        led_d       = 1'b0;

        half_period = (val_q == '0) ? PWM_W'(1) : val_q;
        blink_next  = {1'b0, blink_cnt_q} + 1'b1;

        // A write restarts the channel and swallows a coincident tick.
        if (load) begin
            mode_d      = decode_mode(mode);
            val_d       = val;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
            ramp_d      = '0;
            dir_down_d  = 1'b0;
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: begin
                    if (blink_next == {1'b0, half_period}) begin
                        phase_d     = ~phase_q;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_next[PWM_W-1:0];
                    end
                end
                MODE_BREATHE: begin
                    if (val_q != '0) begin
                        if (!dir_down_q) begin
                            ramp_d = ramp_q + 1'b1;
                            if (ramp_d == val_q) dir_down_d = 1'b1;
                        end else begin
                            ramp_d = ramp_q - 1'b1;
                            if (ramp_d == '0) dir_down_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (mode_q)
            MODE_ON:      led_d = 1'b1;
            MODE_BLINK:   led_d = phase_q;
            MODE_PWM:     led_d = (pwm_cnt < val_q);
            MODE_BREATHE: led_d = (pwm_cnt < ramp_q);
            default:      led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset_in) begin
            mode_q      <= MODE_OFF;
            val_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            ramp_q      <= '0;
            dir_down_q  <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            val_q       <= val_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            ramp_q      <= ramp_d;
            dir_down_q  <= dir_down_d;
            led_q       <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_pattern_driver.sv
// Multi-channel LED pattern driver: shared prescaler and PWM counter, config
// write decode, and one pattern channel per LED.
module led_pattern_driver
    import led_pattern_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int PRESCALE_DIV = 65536,
    parameter int PWM_W        = 8
) (
    input  logic                                       clk_in,
    input  logic                                       reset_in,
    input  logic                                       cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [2:0]                                 cfg_mode,
    input  logic [PWM_W-1:0]                           cfg_val,
    output logic [NUM_CH-1:0]                          led_out,
    output logic                                       tick_out
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRE_W = $clog2(PRESCALE_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             tick_out_q, tick_out_d;
    logic             tick;

    always_comb begin
        tick       = (presc_q == PRE_MAX);
        presc_d    = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        tick_out_d = tick;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            tick_out_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            tick_out_q <= tick_out_d;
        end
    end

    assign tick_out = tick_out_q;

    // Channel indices at or above NUM_CH match no instance, so such writes vanish.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load;
        assign load = cfg_we && (cfg_ch == CH_W'(i));

        led_pattern_channel #(
            .PWM_W (PWM_W)
        ) u_channel (
            .clk_in   (clk_in),
            .reset_in (reset_in),
            .tick     (tick),
            .pwm_cnt  (pwm_cnt_q),
            .load     (load),
            .mode     (cfg_mode),
            .val      (cfg_val),
            .led      (led_out[i])
        );
    end

endmodule
